// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C command arbiter: FSM state encoding,
// ACK polarity, default command width and a command field helper.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_END = 3'd1,
        FAIL     = 3'd2,
        RELEASE  = 3'd3,
        GAP      = 3'd4,
        RETRY    = 3'd5
    } arb_state_e;

    // The controller reports ACK low when the slave acknowledged.
    localparam logic ACK_OK     = 1'b0;
    localparam int   DEF_DATA_W = 24;

    function automatic logic [7:0] slave_addr(input logic [DEF_DATA_W-1:0] cmd);
        return cmd[23:16];
    endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr_i,
// wrapping at N. The pointer register is owned by the parent.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] win_o,
    output logic          vld_o
);

    always_comb begin : pick
        logic [IW:0] j;
        win_o = '0;
        vld_o = 1'b0;
        j     = '0;
        // Walk offsets high-to-low so the closest request to ptr_i is written last.
        for (int i = N - 1; i >= 0; i--) begin
            j = {1'b0, ptr_i} + (IW+1)'(i);
            if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
            if (req_i[j[IW-1:0]]) begin
                win_o = j[IW-1:0];
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C_Controller between NUM_REQ requesters: round-robin grant,
// GO/END handshake, ACK check, bounded retry on NACK or timeout, done/err pulses.
module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 3,
    parameter  int DATA_W         = DEF_DATA_W,
    parameter  int MAX_RETRY      = 3,
    parameter  int GAP_CYCLES     = 16,
    parameter  int TIMEOUT_CYCLES = 200000,
    localparam int OW             = $clog2(NUM_REQ)
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic [NUM_REQ-1:0]        iREQ,
    input  logic [NUM_REQ*DATA_W-1:0] iREQ_DATA,
    output logic [NUM_REQ-1:0]        oGNT,
    output logic [NUM_REQ-1:0]        oDONE,
    output logic [NUM_REQ-1:0]        oERR,
    output logic                      oBUSY,
    output logic [OW-1:0]             oOWNER,
    output logic [DATA_W-1:0]         oI2C_DATA,
    output logic                      oI2C_GO,
    input  logic                      iI2C_END,
    input  logic                      iI2C_ACK
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0]      T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]      G_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0]      R_MAX    = RW'(MAX_RETRY);
    localparam logic [OW-1:0]      OWN_LAST = OW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    arb_state_e           state_q;
    logic [GW-1:0]        gap_q;
    logic [TW-1:0]        tmo_q;
    logic [RW-1:0]        retry_q;
    logic                 retry_pend_q;
    logic [OW-1:0]        ptr_q;
    logic [OW-1:0]        ptr_d;
    logic [OW-1:0]        owner_q;
    logic [DATA_W-1:0]    data_q;
    logic                 go_q;
    logic                 busy_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [NUM_REQ-1:0]   err_q;

    logic [OW-1:0]        win;
    logic                 win_vld;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i (iREQ),
        .ptr_i (ptr_q),
        .win_o (win),
        .vld_o (win_vld)
    );

    // Pointer moves past the owner once its transaction is finished either way.
    assign ptr_d = (owner_q == OWN_LAST) ? '0 : owner_q + 1'b1;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= GAP;
            gap_q        <= '0;
            tmo_q        <= '0;
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
            ptr_q        <= '0;
            owner_q      <= '0;
            data_q       <= '0;
            go_q         <= 1'b0;
            busy_q       <= 1'b0;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        data_q  <= iREQ_DATA[win*DATA_W +: DATA_W];
                        owner_q <= win;
                        gnt_q   <= ONE << win;
                        go_q    <= 1'b1;
                        retry_q <= '0;
                        tmo_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_END;
                    end
                end
                WAIT_END: begin
                    // END is checked before the timeout so a same-cycle END wins.
                    if (iI2C_END) begin
                        go_q <= 1'b0;
                        if (iI2C_ACK == ACK_OK) begin
                            done_q  <= ONE << owner_q;
                            ptr_q   <= ptr_d;
                            state_q <= RELEASE;
                        end else begin
                            state_q <= FAIL;
                        end
                    end else if (tmo_q == T_LAST) begin
                        go_q    <= 1'b0;
                        state_q <= FAIL;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                FAIL: begin
                    if (retry_q < R_MAX) begin
                        retry_q      <= retry_q + 1'b1;
                        retry_pend_q <= 1'b1;
                    end else begin
                        err_q <= ONE << owner_q;
                        ptr_q <= ptr_d;
                    end
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!iI2C_END) begin
                        gap_q   <= '0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == G_LAST) begin
                        gap_q   <= '0;
                        busy_q  <= retry_pend_q;
                        state_q <= retry_pend_q ? RETRY : IDLE;
                    end else begin
                        gap_q  <= gap_q + 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                RETRY: begin
                    go_q         <= 1'b1;
                    tmo_q        <= '0;
                    retry_pend_q <= 1'b0;
                    state_q      <= WAIT_END;
                end
                default: begin
                    go_q    <= 1'b0;
                    gap_q   <= '0;
                    state_q <= GAP;
                end
            endcase
        end
    end

    assign oGNT      = gnt_q;
    assign oDONE     = done_q;
    assign oERR      = err_q;
    assign oBUSY     = busy_q;
    assign oOWNER    = owner_q;
    assign oI2C_DATA = data_q;
    assign oI2C_GO   = go_q;

endmodule
